// File: rtl/adapt_seq_ctrl.sv
// Sequencer for an adaptive FIR filter: shifts the delay lines, runs the MAC
// phase, optionally walks the taps for a weight update, then hands off the error.
module adapt_seq_ctrl #(
    parameter int unsigned TAPS       = 16,
    parameter int unsigned MAC_CYCLES = 18,
    parameter int unsigned MU_SHIFT   = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        adapt_en,
    input  logic        abort,
    input  logic [31:0] err_in,
    output logic        shift_en,
    output logic        filt_en,
    output logic        w_we,
    output logic [4:0]  w_idx,
    output logic [31:0] upd_step,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] err_out,
    output logic        busy,
    output logic [15:0] sample_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        MAC,
        UPDATE,
        DONE
    } state_t;

    localparam logic [4:0] MAC_LAST  = 5'(MAC_CYCLES - 1);
    localparam logic [4:0] TAPS_LAST = 5'(TAPS - 1);

    state_t      state;
    logic [4:0]  cnt;
    logic [31:0] err_q;

    // All outputs are registered and reflect the state being entered, so each
    // branch sets the outputs for the next state alongside the transition.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= '0;
            err_q      <= '0;
            sample_cnt <= '0;
            in_ready   <= 1'b0;
            shift_en   <= 1'b0;
            filt_en    <= 1'b0;
            w_we       <= 1'b0;
            w_idx      <= '0;
            upd_step   <= '0;
            out_valid  <= 1'b0;
            err_out    <= '0;
            busy       <= 1'b0;
        end else begin
            shift_en <= 1'b0;
            filt_en  <= 1'b0;
            w_we     <= 1'b0;
            w_idx    <= '0;
            if (abort) begin
                state     <= IDLE;
                cnt       <= '0;
                out_valid <= 1'b0;
                in_ready  <= 1'b1;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (in_valid && in_ready) begin
                            state    <= SHIFT;
                            in_ready <= 1'b0;
                            busy     <= 1'b1;
                            shift_en <= 1'b1;
                        end else begin
                            in_ready <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        state   <= MAC;
                        cnt     <= '0;
                        filt_en <= 1'b1;
                    end
                    MAC: begin
                        if (cnt == MAC_LAST) begin
                            cnt      <= '0;
                            err_q    <= err_in;
                            upd_step <= {{MU_SHIFT{err_in[31]}}, err_in[31:MU_SHIFT]};
                            if (adapt_en) begin
                                state <= UPDATE;
                                w_we  <= 1'b1;
                            end else begin
                                state     <= DONE;
                                out_valid <= 1'b1;
                                err_out   <= err_in;
                            end
                        end else begin
                            cnt     <= cnt + 5'd1;
                            filt_en <= 1'b1;
                        end
                    end
                    UPDATE: begin
                        if (cnt == TAPS_LAST) begin
                            cnt       <= '0;
                            state     <= DONE;
                            out_valid <= 1'b1;
                            err_out   <= err_q;
                        end else begin
                            cnt   <= cnt + 5'd1;
                            w_we  <= 1'b1;
                            w_idx <= cnt + 5'd1;
                        end
                    end
                    DONE: begin
                        if (out_ready) begin
                            state      <= IDLE;
                            out_valid  <= 1'b0;
                            in_ready   <= 1'b1;
                            busy       <= 1'b0;
                            sample_cnt <= sample_cnt + 16'd1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adapt_seq_ctrl.sv
// Randomized bench for adapt_seq_ctrl; expected waveforms are derived from the
// phase timing (cycles since accept), not from the controller's state machine.
module tb_adapt_seq_ctrl;

    localparam int TAPS = 16;
    localparam int MC   = 18;
    localparam int MU   = 8;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid, in_ready, adapt_en, abort;
    logic [31:0] err_in;
    logic        shift_en, filt_en, w_we;
    logic [4:0]  w_idx;
    logic [31:0] upd_step;
    logic        out_valid, out_ready;
    logic [31:0] err_out;
    logic        busy;
    logic [15:0] sample_cnt;

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] exp_cnt  = '0;

    adapt_seq_ctrl #(.TAPS(TAPS), .MAC_CYCLES(MC), .MU_SHIFT(MU)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .adapt_en(adapt_en), .abort(abort), .err_in(err_in),
        .shift_en(shift_en), .filt_en(filt_en), .w_we(w_we), .w_idx(w_idx),
        .upd_step(upd_step), .out_valid(out_valid), .out_ready(out_ready),
        .err_out(err_out), .busy(busy), .sample_cnt(sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_shift_en"}, shift_en, 0);
        chk({tag, "_filt_en"}, filt_en, 0);
        chk({tag, "_w_we"}, w_we, 0);
        chk({tag, "_w_idx"}, w_idx, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_err_out"}, err_out, 0);
        chk({tag, "_upd_step"}, upd_step, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_sample_cnt"}, sample_cnt, 0);
    endtask

    // Starts at a negedge in IDLE. t counts cycles after the accept edge (t=1 is SHIFT).
    task automatic run_sample(input bit adapt, input logic [31:0] err_last, input int ready_wait,
                              input int abort_t, input bit abort_done, input bit extra_valid);
        int                 upd_lo, lat_t, t, waited;
        bit                 fin, we;
        logic signed [31:0] s;
        logic [31:0]        step;
        s      = err_last;
        step   = s >>> MU;
        upd_lo = 2 + MC;
        lat_t  = adapt ? 2 + MC + TAPS : 2 + MC;
        chk("accept_in_ready", in_ready, 1);
        in_valid = 1'b1;
        adapt_en = adapt;
        err_in   = $urandom;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        t = 1; waited = 0; fin = 0;
        while (!fin) begin
            we = adapt && t >= upd_lo && t < lat_t;
            chk("shift_en", shift_en, t == 1);
            chk("filt_en", filt_en, t >= 2 && t <= 1 + MC);
            chk("w_we", w_we, we);
            chk("w_idx", w_idx, we ? t - upd_lo : 0);
            if (we) chk("upd_step", upd_step, step);
            chk("out_valid", out_valid, t >= lat_t);
            if (t >= lat_t) chk("err_out", err_out, err_last);
            chk("busy", busy, 1);
            chk("in_ready_busy", in_ready, 0);
            chk("sample_cnt_hold", sample_cnt, exp_cnt);
            err_in    = (t == 1 + MC) ? err_last : $urandom;
            abort     = 1'b0;
            out_ready = 1'b0;
            in_valid  = 1'b0;
            if (t == abort_t) begin
                abort = 1'b1;
                fin   = 1;
            end else if (t >= lat_t) begin
                if (extra_valid && waited < 3) in_valid = 1'b1;
                if (waited >= ready_wait) begin
                    out_ready = 1'b1;
                    fin       = 1;
                    if (abort_done) abort = 1'b1;
                    else exp_cnt++;
                end
                waited++;
            end
            @(posedge clk);
            @(negedge clk);
            t++;
        end
        abort = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
        chk("end_busy", busy, 0);
        chk("end_in_ready", in_ready, 1);
        chk("end_out_valid", out_valid, 0);
        chk("end_w_we", w_we, 0);
        chk("end_filt_en", filt_en, 0);
        chk("end_sample_cnt", sample_cnt, exp_cnt);
        if (extra_valid) begin
            @(posedge clk);
            @(negedge clk);
            chk("no_queue_shift_en", shift_en, 0);
            chk("no_queue_busy", busy, 0);
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; in_valid = 1'b0; adapt_en = 1'b0; abort = 1'b0;
        err_in = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset("por");
        rstn = 1'b1;
        chk("in_ready_before_edge", in_ready, 0);
        @(negedge clk);
        chk("in_ready_after_rst", in_ready, 1);

        // Nominal adaptive sample, non-adaptive sample, negative error
        run_sample(1'b1, 32'h0001_0000, 0, 0, 1'b0, 1'b0);
        run_sample(1'b0, 32'h1234_5678, 0, 0, 1'b0, 1'b0);
        run_sample(1'b1, 32'hFFFF_0000, 0, 0, 1'b0, 1'b0);

        // Back-pressure in DONE with a stray in_valid
        run_sample(1'b1, 32'h8000_0001, 10, 0, 1'b0, 1'b1);

        // Abort mid-update, then abort racing out_ready in DONE
        run_sample(1'b1, 32'h0BAD_F00D, 0, 2 + MC + 5, 1'b0, 1'b0);
        run_sample(1'b1, 32'h7FFF_FFFF, 2, 0, 1'b1, 1'b0);
        run_sample(1'b0, 32'h0000_00FF, 0, 0, 1'b0, 1'b0);

        // Asynchronous reset during MAC
        in_valid = 1'b1; adapt_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_filt_en", filt_en, 1);
        #2 rstn = 1'b0;
        #1 chk_reset("mid_mac_rst");
        exp_cnt = '0;
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        chk("in_ready_after_rst2", in_ready, 1);
        run_sample(1'b1, 32'h0001_0000, 1, 0, 1'b0, 1'b0);

        // sample_cnt wrap
        force dut.sample_cnt = 16'hFFFF;
        #1 release dut.sample_cnt;
        exp_cnt = 16'hFFFF;
        @(negedge clk);
        chk("forced_cnt", sample_cnt, 16'hFFFF);
        run_sample(1'b0, 32'hCAFE_0000, 0, 0, 1'b0, 1'b0);
        chk("cnt_wrapped", sample_cnt, 0);

        // Randomized samples
        for (int i = 0; i < 12; i++) begin
            bit adapt;
            int lat, ab;
            adapt = 1'($urandom_range(0, 1));
            lat   = adapt ? 2 + MC + TAPS : 2 + MC;
            ab    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, lat)) : 0;
            run_sample(adapt, $urandom, int'($urandom_range(0, 4)), ab,
                       1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
